// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 32-point DIT FFT datapath pipeline registers.
//   N_DEF / LANES_DEF : default component width and lanes per beat
//   beat_t            : packed beat {sop, r, i} at the default sizes
//   lane(k, n)        : bit offset of lane k inside a packed r or i bus
//   slice_state_t     : occupancy state of one skid-buffer slice
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int N_DEF     = 16;
  localparam int LANES_DEF = 32;

  typedef struct packed {
    logic                        sop;
    logic [LANES_DEF*N_DEF-1:0]  r;
    logic [LANES_DEF*N_DEF-1:0]  i;
  } beat_t;

  // EMPTY: nothing held; BUSY: main register holds a beat; FULL: main and skid hold beats
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } slice_state_t;

  function automatic int lane(input int k, input int n = N_DEF);
    return k * n;
  endfunction

endpackage

// File: rtl/fft_pipe_slice.sv
// ---------------------------------------------------------------------------
// fft_pipe_slice
// One skid-buffer slice: a main register feeding the output and a skid
// register that catches the beat arriving in the cycle the downstream stalls.
// The upstream ready is a flop, so no combinational path runs from i_ready
// back to o_ready.
//   clk, rst   : clock, asynchronous active-high reset
//   i_flush    : synchronous clear of both valid flags (data kept)
//   i_valid    : upstream beat valid       o_ready : slice can accept
//   i_data     : upstream beat
//   o_valid    : main register holds beat  i_ready : downstream accepts
//   o_data     : main register contents
// ---------------------------------------------------------------------------
module fft_pipe_slice
  import fft_pkg::*;
#(
  parameter int WIDTH = 2*LANES_DEF*N_DEF+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  slice_state_t     r_state;
  slice_state_t     w_state_next;
  logic             r_ready;
  logic [WIDTH-1:0] r_m_data;
  logic [WIDTH-1:0] r_s_data;

  logic w_accept;
  logic w_drain;
  logic w_load_m_in;
  logic w_load_m_skid;
  logic w_load_s;

  assign o_valid  = (r_state != ST_EMPTY);
  assign o_ready  = r_ready;
  assign o_data   = r_m_data;
  assign w_accept = i_valid & r_ready;
  assign w_drain  = o_valid & i_ready;

  always_comb begin
    w_state_next  = r_state;
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;
    if (i_flush) begin
      // flush wins over any handshake in the same cycle; no data loads
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_BUSY;
            w_load_m_in  = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_accept && !w_drain) begin
            // main is stalled: park the new beat in the skid register
            w_state_next = ST_FULL;
            w_load_s     = 1'b1;
          end else if (w_drain && !w_accept) begin
            w_state_next = ST_EMPTY;
          end else if (w_accept && w_drain) begin
            w_load_m_in  = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_state_next  = ST_BUSY;
            w_load_m_skid = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_next;
      // ready is computed from the next state so it is valid the cycle it is seen
      r_ready <= (w_state_next != ST_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_data <= '0;
      r_s_data <= '0;
    end else begin
      if (w_load_m_in) begin
        r_m_data <= i_data;
      end else if (w_load_m_skid) begin
        r_m_data <= r_s_data;
      end
      if (w_load_s) begin
        r_s_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/fft_stage_pipe.sv
// ---------------------------------------------------------------------------
// fft_stage_pipe
// Flow-controlled pipeline register between FFT butterfly stages. A chain of
// DEPTH skid-buffer slices carries LANES complex samples plus a start-of-frame
// flag at one beat per cycle; the beat is passed through bit-exact.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous discard of every held beat
//   in_valid/in_ready : upstream handshake (in_ready is a flop)
//   in_sop, in_r, in_i: upstream beat; lane k at [k*N +: N]
//   out_valid/out_ready, out_sop, out_r, out_i : downstream side
//   level             : beats currently held, 0..2*DEPTH
// ---------------------------------------------------------------------------
module fft_stage_pipe
  import fft_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sop,
  input  logic [LANES*N-1:0]             in_r,
  input  logic [LANES*N-1:0]             in_i,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sop,
  output logic [LANES*N-1:0]             out_r,
  output logic [LANES*N-1:0]             out_i,
  output logic [$clog2(2*DEPTH+1)-1:0]   level
);

  localparam int WIDTH = 2*LANES*N+1;
  localparam int LVL_W = $clog2(2*DEPTH+1);

  // Node gi is the link feeding slice gi; node DEPTH is the block output.
  logic             w_valid [0:DEPTH];
  logic             w_ready [0:DEPTH];
  logic [WIDTH-1:0] w_data  [0:DEPTH];

  logic             w_accept;
  logic             w_drain;
  logic [LVL_W-1:0] r_level;

  assign w_valid[0]                = in_valid;
  assign w_data[0]                 = {in_sop, in_r, in_i};
  assign in_ready                  = w_ready[0];
  assign w_ready[DEPTH]            = out_ready;
  assign out_valid                 = w_valid[DEPTH];
  assign {out_sop, out_r, out_i}   = w_data[DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_slice
      fft_pipe_slice #(
        .WIDTH (WIDTH)
      ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (w_valid[gi]),
        .o_ready (w_ready[gi]),
        .i_data  (w_data[gi]),
        .o_valid (w_valid[gi+1]),
        .i_ready (w_ready[gi+1]),
        .o_data  (w_data[gi+1])
      );
    end
  endgenerate

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;
  assign level    = r_level;

  // Handshakes at both ends are the only way beats enter or leave, so a
  // single up/down counter tracks total occupancy across all slices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else if (flush) begin
      r_level <= '0;
    end else if (w_accept && !w_drain) begin
      r_level <= r_level + LVL_W'(1);
    end else if (w_drain && !w_accept) begin
      r_level <= r_level - LVL_W'(1);
    end
  end

endmodule

// File: tb/tb_fft_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_pipe
// Directed and randomised stimulus for fft_stage_pipe (N=16, LANES=32,
// DEPTH=2) with a queue scoreboard of accepted beats and an occupancy check
// every cycle.
// ---------------------------------------------------------------------------
module tb_fft_stage_pipe;
  import fft_pkg::*;

  localparam int N     = 16;
  localparam int LANES = 32;
  localparam int DEPTH = 2;
  localparam int DW    = LANES*N;
  localparam int LW    = $clog2(2*DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_sop;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic [LW-1:0] level;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  int    cyc = 0;
  logic  last_acc = 1'b0;
  int    n_drn = 0;
  int    first_drn = -1;
  int    last_drn_cyc = -1;

  always #5 clk = ~clk;

  fft_stage_pipe #(
    .N     (N),
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_r     (out_r),
    .out_i     (out_i),
    .level     (level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_beat(input beat_t got, input beat_t exp);
    check("beat_sop", 64'(got.sop), 64'(exp.sop));
    for (int k = 0; k < LANES; k++) begin
      check($sformatf("beat_r%0d", k), 64'(got.r[lane(k) +: N]), 64'(exp.r[lane(k) +: N]));
      check($sformatf("beat_i%0d", k), 64'(got.i[lane(k) +: N]), 64'(exp.i[lane(k) +: N]));
    end
  endtask

  // lane k real = 32*b+k; imag offset so r/i swaps are visible
  function automatic beat_t make_beat(input int b, input logic sop);
    beat_t bt;
    bt.sop = sop;
    for (int k = 0; k < LANES; k++) begin
      bt.r[lane(k) +: N] = 16'(32*b + k);
      bt.i[lane(k) +: N] = 16'(16'h4000 + 32*b + k);
    end
    return bt;
  endfunction

  function automatic beat_t rand_beat(input logic sop);
    beat_t bt;
    bt.sop = sop;
    for (int k = 0; k < LANES; k++) begin
      bt.r[lane(k) +: N] = 16'($urandom);
      bt.i[lane(k) +: N] = 16'($urandom);
    end
    return bt;
  endfunction

  task automatic drive(input beat_t bt);
    in_sop = bt.sop;
    in_r   = bt.r;
    in_i   = bt.i;
  endtask

  function automatic beat_t in_beat();
    beat_t bt;
    bt = {in_sop, in_r, in_i};
    return bt;
  endfunction

  function automatic beat_t out_beat();
    beat_t bt;
    bt = {out_sop, out_r, out_i};
    return bt;
  endfunction

  // Resolve the handshakes about to happen at the next edge, advance one
  // clock, then compare occupancy with the scoreboard.
  task automatic tick();
    logic  acc;
    logic  drn;
    beat_t exp_b;
    acc = in_valid & in_ready;
    drn = out_valid & out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (drn) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          exp_b = q.pop_front();
          $display("cyc %0d out sop=%0b lane0_r=%h lane31_i=%h", cyc, out_sop,
                   out_r[N-1:0], out_i[lane(31) +: N]);
          check_beat(out_beat(), exp_b);
        end
        n_drn++;
        if (first_drn < 0) first_drn = cyc;
        last_drn_cyc = cyc;
      end
      if (acc) q.push_back(in_beat());
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
    check("level", 64'(level), 64'(q.size()));
  endtask

  initial begin
    beat_t bt;
    int    b;
    int    nacc;
    int    sent;

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(make_beat(0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;

    // 1: reset while three beats are held
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(make_beat(i, i == 0));
      tick();
    end
    check("t1_level3", 64'(level), 64'd3);
    rst = 1'b1;
    q.delete();
    #1;
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_out_r_zero", 64'(|out_r), 64'd0);
    check("t1_level", 64'(level), 64'd0);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("t1_no_accept_in_rst", 64'(level), 64'd0);
    check("t1_hold_out_valid", 64'(out_valid), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;

    // 2: eight back-to-back beats, no stall
    n_drn = 0; first_drn = -1; last_drn_cyc = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(make_beat(i, i == 0));
      in_valid = 1'b1;
      tick();
      if (i == 0) begin
        check("t2_first_accept", 64'(last_acc), 64'd1);
        check("t2_lat_edge1", 64'(out_valid), 64'd0);
      end
      if (i == 1) check("t2_lat_edge2", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && n_drn < 8; i++) tick();
    check("t2_drains", 64'(n_drn), 64'd8);
    check("t2_no_bubbles", 64'(last_drn_cyc - first_drn), 64'd7);

    // 3: stall with continuous offer
    n_drn = 0; nacc = 0; b = 8;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(make_beat(b, 1'b1));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) begin
        nacc++;
        b++;
        drive(make_beat(b, 1'b0));
      end
    end
    check("t3_accepted", 64'(nacc), 64'd4);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_level", 64'(level), 64'd4);
    check("t3_out_valid", 64'(out_valid), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && level != 0; i++) tick();
    check("t3_drains", 64'(n_drn), 64'd4);
    check("t3_level_end", 64'(level), 64'd0);

    // 4: flush with level 3 and a beat offered in the flush cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(make_beat(20 + i, i == 0));
      tick();
    end
    check("t4_level3", 64'(level), 64'd3);
    flush = 1'b1;
    drive(make_beat(99, 1'b1));
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t4_level", 64'(level), 64'd0);
    check("t4_out_valid", 64'(out_valid), 64'd0);
    check("t4_in_ready", 64'(in_ready), 64'd1);
    n_drn     = 0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("t4_nothing_out", 64'(n_drn), 64'd0);

    // 5: extreme values pass bit-exact, sop only on its own beat
    bt = '0;
    bt.sop = 1'b1;
    bt.r[N-1:0] = 16'h8000;
    bt.i[lane(31) +: N] = 16'hFFFF;
    drive(bt);
    in_valid = 1'b1;
    tick();
    drive(make_beat(5, 1'b0));
    tick();
    check("t5_out_valid", 64'(out_valid), 64'd1);
    check("t5_sop", 64'(out_sop), 64'd1);
    check("t5_lane0_r", 64'(out_r[N-1:0]), 64'h8000);
    check("t5_lane31_i", 64'(out_i[lane(31) +: N]), 64'hFFFF);
    in_valid = 1'b0;
    tick();
    check("t5_next_valid", 64'(out_valid), 64'd1);
    check("t5_next_sop", 64'(out_sop), 64'd0);
    repeat (3) tick();

    // 6: random valid/ready, 2000 beats
    n_drn = 0; sent = 0;
    drive(rand_beat(1'b1));
    for (int c = 0; c < 40000 && sent < 2000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_acc) begin
        sent++;
        drive(rand_beat((sent % 8) == 0));
      end
    end
    check("t6_sent", 64'(sent), 64'd2000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    check("t6_received", 64'(n_drn), 64'd2000);
    check("t6_level_end", 64'(level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
